// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
//
// MEM/WB pipeline register with a small load-wait controller. Non-load
// instructions and loads whose data is already available pass through in one
// cycle. A load whose data is not yet ready parks in WAIT, holds the rest of
// the pipe through mem_stall, and writes back once mem_ready arrives. A
// saturating wait counter raises a sticky mem_timeout when a load waits too
// long.
//
// Handshake: valid_in qualifies the MEM-stage slot on every rising edge where
// the stage is not stalled. mem_ready qualifies mem_read_data_in in the same
// cycle. mem_stall is combinational and tells upstream stages to hold their
// contents while a load is waiting; it drops in the cycle mem_ready rises.
//
// Ports:
//   clk              in   1   clock, all state updates on the rising edge
//   rst              in   1   asynchronous active-high reset
//   valid_in         in   1   MEM slot holds a real instruction
//   mem_to_reg_in    in   1   instruction is a load
//   reg_write_in     in   1   instruction writes the register file
//   reg_rd_in        in   4   destination register
//   alu_result_in    in  16   ALU result carried through MEM
//   mem_read_data_in in  16   data-memory read data
//   mem_ready        in   1   read data valid this cycle
//   ret_future_in    in   1   pending return flag from MEM
//   stall_in         in   1   hold request from hazard control
//   flush_in         in   1   squash request from branch/return resolution
//   wb_data          out 16   register-file write data
//   wb_rd            out  4   register-file write address
//   wb_we            out  1   register-file write enable (single-cycle pulse)
//   ret_wb           out  1   registered return flag (single-cycle pulse)
//   mem_stall        out  1   combinational stall request to upstream stages
//   mem_timeout      out  1   sticky load-timeout error flag
// -----------------------------------------------------------------------------
module mem_wb_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] mem_read_data_in,
    input  logic        mem_ready,
    input  logic        ret_future_in,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_we,
    output logic        ret_wb,
    output logic        mem_stall,
    output logic        mem_timeout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'hF;

    // Registered state
    state_t      state;
    logic [3:0]  wait_cnt;
    logic [3:0]  pend_rd;
    logic        pend_we;
    logic        pend_ret;

    // Next-state values
    state_t      state_next;
    logic [3:0]  wait_cnt_next;
    logic [3:0]  pend_rd_next;
    logic        pend_we_next;
    logic        pend_ret_next;
    logic [15:0] wb_data_next;
    logic [3:0]  wb_rd_next;
    logic        wb_we_next;
    logic        ret_wb_next;
    logic        mem_timeout_next;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            pend_rd     <= 4'd0;
            pend_we     <= 1'b0;
            pend_ret    <= 1'b0;
            wb_data     <= 16'h0000;
            wb_rd       <= 4'd0;
            wb_we       <= 1'b0;
            ret_wb      <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            pend_rd     <= pend_rd_next;
            pend_we     <= pend_we_next;
            pend_ret    <= pend_ret_next;
            wb_data     <= wb_data_next;
            wb_rd       <= wb_rd_next;
            wb_we       <= wb_we_next;
            ret_wb      <= ret_wb_next;
            mem_timeout <= mem_timeout_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    //
    // wb_we and ret_wb default to 0 every cycle so each instruction produces at
    // most one write/return pulse. That also covers a stalled IDLE cycle: the
    // data and address hold, but a write that already happened is not repeated.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        wait_cnt_next    = wait_cnt;
        pend_rd_next     = pend_rd;
        pend_we_next     = pend_we;
        pend_ret_next    = pend_ret;
        wb_data_next     = wb_data;
        wb_rd_next       = wb_rd;
        wb_we_next       = 1'b0;
        ret_wb_next      = 1'b0;
        mem_timeout_next = mem_timeout;

        if (flush_in) begin
            // Squash: drop any parked load; the timeout flag is an error
            // record and survives the flush.
            state_next    = IDLE;
            wait_cnt_next = 4'd0;
            pend_rd_next  = 4'd0;
            pend_we_next  = 1'b0;
            pend_ret_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall_in) begin
                        // Hold everything; pulses already defaulted low.
                    end else if (valid_in) begin
                        if (mem_to_reg_in && !mem_ready) begin
                            // Load data not here yet: park the control fields.
                            pend_rd_next  = reg_rd_in;
                            pend_we_next  = reg_write_in;
                            pend_ret_next = ret_future_in;
                            wait_cnt_next = 4'd0;
                            state_next    = WAIT;
                        end else begin
                            wb_data_next = mem_to_reg_in ? mem_read_data_in
                                                         : alu_result_in;
                            wb_rd_next   = reg_rd_in;
                            wb_we_next   = reg_write_in;
                            ret_wb_next  = ret_future_in;
                        end
                    end
                end

                WAIT: begin
                    // stall_in is deliberately ignored here: the pipe is
                    // already held by mem_stall and the load must complete.
                    if (mem_ready) begin
                        wb_data_next  = mem_read_data_in;
                        wb_rd_next    = pend_rd;
                        wb_we_next    = pend_we;
                        ret_wb_next   = pend_ret;
                        wait_cnt_next = 4'd0;
                        state_next    = IDLE;
                    end else begin
                        if (wait_cnt != CNT_MAX) begin
                            wait_cnt_next = wait_cnt + 4'd1;
                        end
                        if (wait_cnt_next == CNT_MAX) begin
                            mem_timeout_next = 1'b1;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Stall upstream only while a parked load is still missing its data.
    // Gated by rst so the request is low for the whole reset pulse.
    assign mem_stall = (state == WAIT) && !mem_ready && !rst;

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        mem_to_reg_in;
    logic        reg_write_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result_in;
    logic [15:0] mem_read_data_in;
    logic        mem_ready;
    logic        ret_future_in;
    logic        stall_in;
    logic        flush_in;
    logic [15:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_we;
    logic        ret_wb;
    logic        mem_stall;
    logic        mem_timeout;

    // Scoreboard entry: {wb_we, ret_wb, wb_rd, wb_data}
    logic [21:0] exp_q[$];
    logic [21:0] exp;
    logic [21:0] got;

    int tests;
    int failed;

    mem_wb_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .mem_to_reg_in    (mem_to_reg_in),
        .reg_write_in     (reg_write_in),
        .reg_rd_in        (reg_rd_in),
        .alu_result_in    (alu_result_in),
        .mem_read_data_in (mem_read_data_in),
        .mem_ready        (mem_ready),
        .ret_future_in    (ret_future_in),
        .stall_in         (stall_in),
        .flush_in         (flush_in),
        .wb_data          (wb_data),
        .wb_rd            (wb_rd),
        .wb_we            (wb_we),
        .ret_wb           (ret_wb),
        .mem_stall        (mem_stall),
        .mem_timeout      (mem_timeout)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bubble();
        valid_in         = 1'b0;
        mem_to_reg_in    = 1'b0;
        reg_write_in     = 1'b0;
        reg_rd_in        = 4'd0;
        alu_result_in    = 16'h0000;
        mem_read_data_in = 16'h0000;
        mem_ready        = 1'b0;
        ret_future_in    = 1'b0;
        stall_in         = 1'b0;
        flush_in         = 1'b0;
    endtask

    task automatic drive_op(input logic load, input logic we, input logic [3:0] rd,
                            input logic [15:0] alu, input logic [15:0] mdata,
                            input logic ready, input logic ret);
        valid_in         = 1'b1;
        mem_to_reg_in    = load;
        reg_write_in     = we;
        reg_rd_in        = rd;
        alu_result_in    = alu;
        mem_read_data_in = mdata;
        mem_ready        = ready;
        ret_future_in    = ret;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_bubble();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({wb_data, wb_rd, wb_we, ret_wb, mem_stall, mem_timeout} !== 26'd0) begin
            failed++;
            $display("FAIL reset_values: got data=%h rd=%h we=%b ret=%b stall=%b to=%b, expected all zero",
                     wb_data, wb_rd, wb_we, ret_wb, mem_stall, mem_timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_op();
        drive_op(1'b0, 1'b1, 4'd3, 16'h1234, 16'h0000, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 4'd3, 16'h1234});
        tick();
        exp = exp_q.pop_front();
        got = {wb_we, ret_wb, wb_rd, wb_data};
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL alu_op: got %h expected %h", got, exp);
        end
        drive_bubble();
        tick();
        got = {wb_we, ret_wb, wb_rd, wb_data};
        tests++;
        if (got !== {1'b0, 1'b0, 4'd3, 16'h1234}) begin
            failed++;
            $display("FAIL bubble_hold: got %h expected %h", got, {1'b0, 1'b0, 4'd3, 16'h1234});
        end
    endtask

    task automatic test_back_to_back();
        logic        load;
        logic        we;
        logic        ret;
        logic [3:0]  rd;
        logic [15:0] alu;
        logic [15:0] mdata;
        for (int i = 0; i < 10; i++) begin
            load  = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            ret   = 1'($urandom_range(0, 1));
            rd    = 4'($urandom_range(0, 15));
            alu   = 16'($urandom_range(0, 65535));
            mdata = 16'($urandom_range(0, 65535));
            drive_op(load, we, rd, alu, mdata, 1'b1, ret);
            exp_q.push_back({we, ret, rd, load ? mdata : alu});
            tick();
            exp = exp_q.pop_front();
            got = {wb_we, ret_wb, wb_rd, wb_data};
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp);
            end
        end
        drive_bubble();
        tick();
    endtask

    task automatic test_load_wait();
        int stall_cycles;
        stall_cycles = 0;
        drive_op(1'b1, 1'b1, 4'd5, 16'h7777, 16'h0000, 1'b0, 1'b1);
        exp_q.push_back({1'b1, 1'b1, 4'd5, 16'hBEEF});
        tick();
        drive_bubble();
        for (int i = 0; i < 2; i++) begin
            #1;
            if (mem_stall === 1'b1 && wb_we === 1'b0) stall_cycles++;
            tick();
        end
        tests++;
        if (stall_cycles != 2) begin
            failed++;
            $display("FAIL load_wait_stall: got %0d stalled cycles expected 2", stall_cycles);
        end
        // Completion with a stall request present: must be ignored in WAIT.
        mem_ready        = 1'b1;
        mem_read_data_in = 16'hBEEF;
        stall_in         = 1'b1;
        #1;
        tests++;
        if (mem_stall !== 1'b0) begin
            failed++;
            $display("FAIL load_stall_drop: got %b expected 0", mem_stall);
        end
        tick();
        exp = exp_q.pop_front();
        got = {wb_we, ret_wb, wb_rd, wb_data};
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL load_wait_wb: got %h expected %h", got, exp);
        end
        drive_bubble();
        tick();
        tests++;
        if ({wb_we, ret_wb, mem_stall} !== 3'b000) begin
            failed++;
            $display("FAIL load_single_pulse: got we/ret/stall=%b%b%b expected 000", wb_we, ret_wb, mem_stall);
        end
    endtask

    task automatic test_flush_wait();
        drive_op(1'b1, 1'b1, 4'd8, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive_bubble();
        flush_in = 1'b1;
        tick();
        tests++;
        if ({wb_we, mem_stall} !== 2'b00) begin
            failed++;
            $display("FAIL flush_wait: got we=%b stall=%b expected 0 0", wb_we, mem_stall);
        end
        flush_in         = 1'b0;
        mem_ready        = 1'b1;
        mem_read_data_in = 16'hDEAD;
        tick();
        tests++;
        if (wb_we !== 1'b0 || wb_data === 16'hDEAD) begin
            failed++;
            $display("FAIL flush_no_write: got we=%b data=%h expected we=0 and no DEAD", wb_we, wb_data);
        end
        drive_bubble();
        tick();
    endtask

    task automatic test_timeout();
        drive_op(1'b1, 1'b1, 4'd2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive_bubble();
        repeat (10) tick();
        tests++;
        if (mem_timeout !== 1'b0) begin
            failed++;
            $display("FAIL timeout_early: got %b expected 0", mem_timeout);
        end
        repeat (6) tick();
        tests++;
        if ({mem_timeout, mem_stall} !== 2'b11) begin
            failed++;
            $display("FAIL timeout_set: got to=%b stall=%b expected 1 1", mem_timeout, mem_stall);
        end
        mem_ready        = 1'b1;
        mem_read_data_in = 16'h0F0F;
        exp_q.push_back({1'b1, 1'b0, 4'd2, 16'h0F0F});
        tick();
        exp = exp_q.pop_front();
        got = {wb_we, ret_wb, wb_rd, wb_data};
        tests++;
        if (got !== exp || mem_timeout !== 1'b1) begin
            failed++;
            $display("FAIL timeout_complete: got %h to=%b expected %h to=1", got, mem_timeout, exp);
        end
        drive_bubble();
        flush_in = 1'b1;
        tick();
        tests++;
        if (mem_timeout !== 1'b1) begin
            failed++;
            $display("FAIL timeout_sticky_flush: got %b expected 1", mem_timeout);
        end
        flush_in = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (mem_timeout !== 1'b0) begin
            failed++;
            $display("FAIL timeout_rst_clear: got %b expected 0", mem_timeout);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stall_flush();
        drive_op(1'b0, 1'b1, 4'd4, 16'h1111, 16'h0000, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 4'd4, 16'h1111});
        tick();
        exp = exp_q.pop_front();
        got = {wb_we, ret_wb, wb_rd, wb_data};
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL stall_setup: got %h expected %h", got, exp);
        end
        drive_bubble();
        tick();
        drive_op(1'b0, 1'b1, 4'd6, 16'h2222, 16'h0000, 1'b0, 1'b1);
        stall_in = 1'b1;
        flush_in = 1'b1;
        tick();
        tests++;
        if ({wb_we, ret_wb} !== 2'b00) begin
            failed++;
            $display("FAIL stall_flush_prio: got we=%b ret=%b expected 0 0", wb_we, ret_wb);
        end
        flush_in = 1'b0;
        tick();
        got = {wb_we, ret_wb, wb_rd, wb_data};
        tests++;
        if (got !== {1'b0, 1'b0, 4'd4, 16'h1111}) begin
            failed++;
            $display("FAIL stall_hold: got %h expected %h", got, {1'b0, 1'b0, 4'd4, 16'h1111});
        end
        stall_in = 1'b0;
        exp_q.push_back({1'b1, 1'b1, 4'd6, 16'h2222});
        tick();
        exp = exp_q.pop_front();
        got = {wb_we, ret_wb, wb_rd, wb_data};
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL stall_release: got %h expected %h", got, exp);
        end
        drive_bubble();
        tick();
    endtask

    task automatic test_async_reset();
        drive_op(1'b0, 1'b1, 4'd7, 16'hA5A5, 16'h0000, 1'b0, 1'b1);
        tick();
        drive_op(1'b1, 1'b1, 4'd9, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick();
        drive_bubble();
        #1;
        tests++;
        if ({mem_stall, wb_data} !== {1'b1, 16'hA5A5}) begin
            failed++;
            $display("FAIL async_setup: got stall=%b data=%h expected 1 a5a5", mem_stall, wb_data);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({wb_data, wb_rd, wb_we, ret_wb, mem_stall, mem_timeout} !== 26'd0) begin
            failed++;
            $display("FAIL async_reset: got data=%h rd=%h we=%b ret=%b stall=%b to=%b expected all zero",
                     wb_data, wb_rd, wb_we, ret_wb, mem_stall, mem_timeout);
        end
        #1;
        rst              = 1'b0;
        mem_ready        = 1'b1;
        mem_read_data_in = 16'hC0DE;
        tick();
        tests++;
        if ({wb_we, ret_wb, mem_stall} !== 3'b000 || wb_data === 16'hC0DE) begin
            failed++;
            $display("FAIL async_no_wb: got we=%b ret=%b stall=%b data=%h expected no writeback",
                     wb_we, ret_wb, mem_stall, wb_data);
        end
        drive_bubble();
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        drive_bubble();
        test_reset();
        test_alu_op();
        test_back_to_back();
        test_load_wait();
        test_flush_wait();
        test_timeout();
        test_stall_flush();
        test_async_reset();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port valid_in, input, 1, MEM-stage slot holds a real instruction.
REQ-004 SHALL have port mem_to_reg_in, input, 1, instruction is a load; writeback data comes from memory.
REQ-005 SHALL have port reg_write_in, input, 1, instruction writes the register file.
REQ-006 SHALL have port reg_rd_in, input, 4, destination register.
REQ-007 SHALL have port alu_result_in, input, 16, ALU result forwarded through MEM.
REQ-008 SHALL have port mem_read_data_in, input, 16, data-memory read data.
REQ-009 SHALL have port mem_ready, input, 1, read data valid this cycle.
REQ-010 SHALL have port ret_future_in, input, 1, pending return flag from MEM.
REQ-011 SHALL have port stall_in, input, 1, hold request from hazard control.
REQ-012 SHALL have port flush_in, input, 1, squash request from branch/return resolution.
REQ-013 SHALL have port wb_data, output, 16, register-file write data.
REQ-014 SHALL have port wb_rd, output, 4, register-file write address.
REQ-015 SHALL have port wb_we, output, 1, register-file write enable.
REQ-016 SHALL have port ret_wb, output, 1, registered return flag.
REQ-017 SHALL have port mem_stall, output, 1, combinational stall request to upstream stages.
REQ-018 SHALL have port mem_timeout, output, 1, sticky load-timeout error flag.

Function
REQ-019 SHALL implement FSM states IDLE and WAIT.
REQ-020 Priority per edge SHALL be rst > flush_in > stall_in > normal operation.
REQ-021 IDLE, valid_in=1, non-load: on the edge, wb_data<=alu_result_in, wb_rd<=reg_rd_in, wb_we<=reg_write_in, ret_wb<=ret_future_in; latency exactly 1 cycle.
REQ-022 IDLE, valid load, mem_ready=1: wb_data<=mem_read_data_in, other fields as REQ-021, remain IDLE.
REQ-023 IDLE, valid load, mem_ready=0: latch reg_rd_in, reg_write_in, ret_future_in internally; wb_we<=0, ret_wb<=0; go WAIT; clear wait counter.
REQ-024 mem_stall SHALL be 1 in WAIT while mem_ready=0, and 0 otherwise.
REQ-025 WAIT, mem_ready=1: wb_data<=mem_read_data_in, wb_rd/wb_we/ret_wb<=latched values; go IDLE; mem_stall drops in the same cycle.
REQ-026 WAIT, mem_ready=0: wb_we=0, ret_wb=0; 4-bit wait counter increments, saturating at 15.
REQ-027 Counter reaching 15 in WAIT SHALL set mem_timeout=1, held until rst; FSM stays in WAIT.
REQ-028 valid_in=0 in IDLE (no stall/flush): wb_we<=0, ret_wb<=0; wb_data and wb_rd hold.
REQ-029 flush_in=1 in any state: wb_we<=0, ret_wb<=0, go IDLE, discard latched load; mem_timeout unaffected.
REQ-030 stall_in=1 (no flush) in IDLE: all outputs and state hold.
REQ-031 stall_in in WAIT SHALL be ignored; completion per REQ-025 proceeds.
REQ-032 wb_we SHALL never be 1 for more than one cycle per instruction.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, counter=0, wb_data=0x0000, wb_rd=0, wb_we=0, ret_wb=0, mem_timeout=0; mem_stall=0 while rst is asserted.
REQ-034 rst asserted in WAIT SHALL drop the pending load with no writeback after release.

Verification
REQ-035 ALU op: valid_in=1, reg_write_in=1, rd=3, alu_result_in=0x1234 -> next cycle wb_we=1, wb_rd=3, wb_data=0x1234.
REQ-036 Load, mem_ready low 2 cycles then high with data 0xBEEF, rd=5 -> mem_stall=1 for 2 cycles; wb_we=1, wb_rd=5, wb_data=0xBEEF one cycle after mem_ready; wb_we pulses once.
REQ-037 Load waiting in WAIT, flush_in=1 -> next cycle IDLE, wb_we=0; later mem_ready produces no write.
REQ-038 mem_ready held low 16 cycles in WAIT -> mem_timeout=1 stays set after a later mem_ready and flush; cleared only by rst.
REQ-039 stall_in=1 and flush_in=1 together in IDLE with a valid ALU op -> wb_we=0 next cycle (flush wins).
REQ-040 rst pulsed mid-cycle while in WAIT -> outputs zero without waiting for clk; after release, wb_we=0 and mem_stall=0.
